// File: rtl/parity3_frame_rx_pkg.sv
// parity3_frame_rx_pkg: FSM state encoding and frame constants shared by the receiver and its bench
package parity3_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int FRAME_OVH = 3;

endpackage

// File: rtl/parity3_frame_rx_if.sv
// parity3_frame_rx_if: serial input strobe/line and decoded frame outputs of the receiver
interface parity3_frame_rx_if #(
    parameter int DATA_W = 3
);

    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (output bit_en, rx, input data, valid, parity_err, frame_err, busy);
    modport slave  (input bit_en, rx, output data, valid, parity_err, frame_err, busy);

endinterface

// File: rtl/parity3_frame_rx.sv
// parity3_frame_rx: deserialises start/data(MSB first)/parity/stop frames and flags parity and framing errors
module parity3_frame_rx
    import parity3_frame_rx_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity3_frame_rx_if.slave    rx_if
);

    localparam int CW = $clog2(DATA_W) + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              p_q, p_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        p_d     = p_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        if (rx_if.bit_en) begin
            unique case (state_q)
                IDLE: begin
                    state_d = rx_if.rx ? IDLE : DATA;
                    cnt_d   = rx_if.rx ? cnt_q : '0;
                end
                DATA: begin
                    shreg_d = {shreg_q[DATA_W-2:0], rx_if.rx};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(DATA_W - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    p_d     = rx_if.rx;
                    state_d = STOP;
                end
                STOP: begin
                    data_d  = shreg_q;
                    perr_d  = ^shreg_q ^ p_q ^ ODD_PARITY;
                    ferr_d  = ~rx_if.rx;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            p_q     <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            p_q     <= p_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign rx_if.data       = data_q;
    assign rx_if.valid      = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity3_frame_rx.sv
// tb_parity3_frame_rx: directed and randomized frames into even- and odd-parity receivers, checked against frame-level expectations
module tb_parity3_frame_rx;
    import parity3_frame_rx_pkg::*;

    localparam int DATA_W = 3;
    localparam int FLEN   = DATA_W + FRAME_OVH;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DATA_W-1:0] exp_data;
    logic              exp_pe_e, exp_pe_o, exp_fe;

    parity3_frame_rx_if #(.DATA_W(DATA_W)) ife ();
    parity3_frame_rx_if #(.DATA_W(DATA_W)) ifo ();

    assign ifo.bit_en = ife.bit_en;
    assign ifo.rx     = ife.rx;

    parity3_frame_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) dut_even (.clk(clk), .rst_n(rst_n), .rx_if(ife));
    parity3_frame_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b1)) dut_odd  (.clk(clk), .rst_n(rst_n), .rx_if(ifo));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic eb);
        chk({tag, ".valid"},  8'(ife.valid),      8'(ev));
        chk({tag, ".busy"},   8'(ife.busy),       8'(eb));
        chk({tag, ".data"},   8'(ife.data),       8'(exp_data));
        chk({tag, ".perr"},   8'(ife.parity_err), 8'(exp_pe_e));
        chk({tag, ".ferr"},   8'(ife.frame_err),  8'(exp_fe));
        chk({tag, ".o_valid"}, 8'(ifo.valid),     8'(ev));
        chk({tag, ".o_data"}, 8'(ifo.data),       8'(exp_data));
        chk({tag, ".o_perr"}, 8'(ifo.parity_err), 8'(exp_pe_o));
    endtask

    // Drive one sampled bit after 'gap' strobe-free cycles; outputs are checked on the falling edge.
    task automatic send_bit(input logic b, input int gap, input string tag, input logic gap_busy,
                            input logic ev, input logic eb);
        for (int g = 0; g < gap; g++) begin
            ife.bit_en = 1'b0;
            @(negedge clk);
            check_all({tag, ".gap"}, 1'b0, gap_busy);
        end
        ife.bit_en = 1'b1;
        ife.rx     = b;
        @(negedge clk);
        ife.bit_en = 1'b0;
        ife.rx     = 1'b1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop,
                              input int maxgap, input string tag);
        logic [FLEN-1:0] bits;
        bits = {1'b0, d, p, stop};
        for (int i = 0; i < FLEN; i++) begin
            send_bit(bits[FLEN-1-i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, tag,
                     i > 0, i == FLEN - 1, i < FLEN - 1);
            if (i == FLEN - 1) begin
                exp_data = d;
                exp_pe_e = (^d) ^ p;
                exp_pe_o = (^d) ^ p ^ 1'b1;
                exp_fe   = ~stop;
            end
            check_all(tag, i == FLEN - 1, i < FLEN - 1);
        end
    endtask

    task automatic idle_bits(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1, 0, tag, 1'b0, 1'b0, 1'b0);
            check_all(tag, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic              rp, rs;
        exp_data   = '0;
        exp_pe_e   = 1'b0;
        exp_pe_o   = 1'b0;
        exp_fe     = 1'b0;
        rst_n      = 1'b0;
        ife.bit_en = 1'b0;
        ife.rx     = 1'b1;
        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        idle_bits(10, "idle");

        send_frame(3'b101, 1'b0, 1'b1, 0, "even_ok");
        send_frame(3'b101, 1'b1, 1'b1, 0, "even_bad_par");
        idle_bits(2, "idle2");

        send_frame(3'b110, 1'b0, 1'b0, 0, "bad_stop");
        send_frame(3'b010, 1'b1, 1'b1, 0, "b2b_after_bad_stop");

        for (int v = 0; v < 8; v++) begin
            rd = DATA_W'(v);
            send_frame(rd, ^rd, 1'b1, 5, "sweep");
        end

        for (int k = 0; k < 40; k++) begin
            rd = DATA_W'($urandom_range(0, 7));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rs, 3, "random");
            if ($urandom_range(0, 2) == 0) idle_bits(int'($urandom_range(1, 3)), "random_idle");
        end

        send_bit(1'b0, 0, "abort", 1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1, "abort", 1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 0, "abort", 1'b1, 1'b0, 1'b1);
        check_all("abort_pre", 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_data = '0;
        exp_pe_e = 1'b0;
        exp_pe_o = 1'b0;
        exp_fe   = 1'b0;
        check_all("abort_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2, "abort_idle");
        send_frame(3'b011, 1'b0, 1'b1, 2, "after_abort");
        idle_bits(3, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
